// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit serial CPU: data word, register index,
// register-file size and the writeback FIFO entry.
package cpu_pkg;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  reg_idx_t;

    localparam int REG_COUNT = 8;

    typedef logic [REG_COUNT-1:0] reg_mask_t;

    typedef struct packed {
        reg_idx_t rd;
        word_t    data;
    } wb_entry_t;

    // One-hot mask selecting a single register of the file.
    function automatic reg_mask_t reg_onehot(input reg_idx_t idx);
        reg_mask_t m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the writeback arbiter's handshake, scoreboard-query and
// register-file write-port signals. The slave modport is the arbiter side.
interface wb_arbiter_if;
    import cpu_pkg::*;

    logic     alu_valid;
    reg_idx_t alu_rd;
    word_t    alu_data;
    logic     mem_valid;
    logic     mem_ready;
    reg_idx_t mem_rd;
    word_t    mem_data;
    logic     ld_issue;
    reg_idx_t ld_rd;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     rs1_busy;
    logic     rs2_busy;
    logic     fwd1_hit;
    logic     fwd2_hit;
    word_t    fwd1_data;
    word_t    fwd2_data;
    logic     rd_we;
    reg_idx_t rd;
    word_t    rd_data;

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        input  ld_issue, ld_rd, rs1, rs2,
        output mem_ready, rs1_busy, rs2_busy,
        output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
        output rd_we, rd, rd_data
    );

    modport master (
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        output ld_issue, ld_rd, rs1, rs2,
        input  mem_ready, rs1_busy, rs2_busy,
        input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
        input  rd_we, rd, rd_data
    );

endinterface

// File: rtl/wb_fifo.sv
// Two-entry FIFO holding returned load results ({dest, data}) until the
// write port is free. Full/empty are registered so the upstream ready never
// depends combinationally on this cycle's push or pop.
module wb_fifo
    import cpu_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    wb_entry_t  entries_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       full_q;
    logic       empty_q;
    logic       do_push;
    logic       do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Occupancy after this cycle's push/pop; a simultaneous pair leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    // Pointer and occupancy bookkeeping; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
            full_q  <= (count_d == 2'd2);
            empty_q <= (count_d == 2'd0);
        end
    end

    // Entry storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            entries_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = entries_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and buffered load
// results onto the register file's single write port (ALU has strict
// priority), and keeps a per-register scoreboard of uncommitted loads.
// Build option WB_FWD_EN: forward the committing write to decode instead of
// reporting its destination as busy for that extra cycle.
module wb_arbiter
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    wb_arbiter_if.slave bus
);

    wb_entry_t fifo_head;
    wb_entry_t fifo_push_data;
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;

    logic      win_valid;
    wb_entry_t win;

    logic      rd_we_q, rd_we_d;
    reg_idx_t  rd_q, rd_d;
    word_t     rd_data_q, rd_data_d;
    logic      ld_commit_q, ld_commit_d;
    reg_mask_t busy_q, busy_d;
    reg_mask_t set_mask, clr_mask;

    logic      match1;
    logic      match2;

    assign fifo_push_data = '{rd: bus.mem_rd, data: bus.mem_data};
    assign fifo_push      = bus.mem_valid && !fifo_full;
    assign fifo_pop       = !bus.alu_valid && !fifo_empty;
    assign bus.mem_ready  = !fifo_full;

    wb_fifo u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_push_data),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // Select this cycle's writer: ALU first, otherwise the oldest buffered load.
    always_comb begin
        win_valid = 1'b0;
        win       = fifo_head;
        if (bus.alu_valid) begin
            win_valid = 1'b1;
            win.rd    = bus.alu_rd;
            win.data  = bus.alu_data;
        end else if (!fifo_empty) begin
            win_valid = 1'b1;
        end
    end

    // Next write-port value and scoreboard; a new load issue beats a same-register clear.
    always_comb begin
        rd_we_d     = win_valid && (win.rd != '0);
        rd_d        = win_valid ? win.rd : rd_q;
        rd_data_d   = win_valid ? win.data : rd_data_q;
        ld_commit_d = fifo_pop && (fifo_head.rd != '0);
        set_mask    = '0;
        clr_mask    = '0;
        if (bus.ld_issue && (bus.ld_rd != '0)) begin
            set_mask = reg_onehot(bus.ld_rd);
        end
        if (ld_commit_q) begin
            clr_mask = reg_onehot(rd_q);
        end
        busy_d    = (busy_q & ~clr_mask) | set_mask;
        busy_d[0] = 1'b0;
    end

    // Register the write port and scoreboard; reset drops any pending write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_we_q     <= 1'b0;
            rd_q        <= '0;
            rd_data_q   <= '0;
            ld_commit_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            rd_we_q     <= rd_we_d;
            rd_q        <= rd_d;
            rd_data_q   <= rd_data_d;
            ld_commit_q <= ld_commit_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rd_we   = rd_we_q;
    assign bus.rd      = rd_q;
    assign bus.rd_data = rd_data_q;

    // A source matches when the register file is being written with it right now.
    assign match1 = rd_we_q && (rd_q == bus.rs1) && (bus.rs1 != '0);
    assign match2 = rd_we_q && (rd_q == bus.rs2) && (bus.rs2 != '0);

`ifdef WB_FWD_EN
    assign bus.fwd1_hit  = match1;
    assign bus.fwd2_hit  = match2;
    assign bus.fwd1_data = rd_data_q;
    assign bus.fwd2_data = rd_data_q;
    assign bus.rs1_busy  = busy_q[bus.rs1];
    assign bus.rs2_busy  = busy_q[bus.rs2];
`else
    assign bus.fwd1_hit  = 1'b0;
    assign bus.fwd2_hit  = 1'b0;
    assign bus.fwd1_data = '0;
    assign bus.fwd2_data = '0;
    assign bus.rs1_busy  = busy_q[bus.rs1] | match1;
    assign bus.rs2_busy  = busy_q[bus.rs2] | match2;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: a directed vector table, hand-written reset
// sequences and constrained-random traffic, all checked against a
// queue-based reference model of the writeback rules.
module tb_wb_arbiter;

`ifdef WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] data;
    } ent_t;

    typedef struct {
        logic        av;
        logic [2:0]  ard;
        logic [15:0] ad;
        logic        mv;
        logic [2:0]  mrd;
        logic [15:0] md;
        logic        li;
        logic [2:0]  lrd;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic        ewe;
        logic [2:0]  erd;
        logic [15:0] edata;
        logic        erdy;
        logic        eb1;
        logic        em1;
        logic        eb2;
        logic        em2;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc;

    // Reference model state
    ent_t        m_q[$];
    logic        m_we;
    logic [2:0]  m_rd;
    logic [15:0] m_data;
    logic        m_fromld;
    logic [7:0]  m_busy;

    // Loads issued by decode and not yet handed to the arbiter
    logic [2:0]  iss_q[$];

    vec_t vecs [22];

    wb_arbiter_if bus ();

    wb_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic exp_busy(input logic [2:0] rs);
        logic match;
        match = m_we && (m_rd == rs) && (rs != 3'd0);
        return ((rs != 3'd0) && m_busy[rs]) || (!FWD && match);
    endfunction

    function automatic logic exp_hit(input logic [2:0] rs);
        return FWD && m_we && (m_rd == rs) && (rs != 3'd0);
    endfunction

    task automatic check_model();
        chk("rd_we", 16'(bus.rd_we), 16'(m_we));
        chk("rd", 16'(bus.rd), 16'(m_rd));
        chk("rd_data", bus.rd_data, m_data);
        chk("mem_ready", 16'(bus.mem_ready), 16'(m_q.size() < 2));
        chk("rs1_busy", 16'(bus.rs1_busy), 16'(exp_busy(bus.rs1)));
        chk("rs2_busy", 16'(bus.rs2_busy), 16'(exp_busy(bus.rs2)));
        chk("fwd1_hit", 16'(bus.fwd1_hit), 16'(exp_hit(bus.rs1)));
        chk("fwd2_hit", 16'(bus.fwd2_hit), 16'(exp_hit(bus.rs2)));
        chk("fwd1_data", bus.fwd1_data, FWD ? m_data : 16'h0000);
        chk("fwd2_data", bus.fwd2_data, FWD ? m_data : 16'h0000);
    endtask

    // Advance the model by one clock edge using the inputs of the cycle just ended.
    task automatic model_step();
        logic        clr_v;
        logic [2:0]  clr_r;
        logic        acc;
        logic        wv;
        logic        wld;
        ent_t        w;
        if (!rst_n) begin
            m_q.delete();
            m_we     = 1'b0;
            m_rd     = 3'd0;
            m_data   = 16'h0000;
            m_fromld = 1'b0;
            m_busy   = 8'h00;
            return;
        end
        clr_v = m_we && m_fromld;
        clr_r = m_rd;
        if (bus.ld_issue && bus.ld_rd != 3'd0 && m_busy[bus.ld_rd] && !(clr_v && clr_r == bus.ld_rd)) begin
            errors++;
            $display("FAIL protocol_ld_issue cycle=%0d reg=%0d actual busy=1 required busy=0", cyc, bus.ld_rd);
        end
        if (bus.alu_valid && bus.alu_rd != 3'd0 && m_busy[bus.alu_rd]) begin
            errors++;
            $display("FAIL protocol_alu_write cycle=%0d reg=%0d actual busy=1 required busy=0", cyc, bus.alu_rd);
        end
        acc = bus.mem_valid && (m_q.size() < 2);
        wv  = 1'b0;
        wld = 1'b0;
        w   = '0;
        if (bus.alu_valid) begin
            wv = 1'b1;
            w  = '{rd: bus.alu_rd, data: bus.alu_data};
        end else if (m_q.size() > 0) begin
            wv  = 1'b1;
            wld = 1'b1;
            w   = m_q.pop_front();
        end
        if (acc) m_q.push_back('{rd: bus.mem_rd, data: bus.mem_data});
        if (clr_v) m_busy[clr_r] = 1'b0;
        if (bus.ld_issue && bus.ld_rd != 3'd0) m_busy[bus.ld_rd] = 1'b1;
        m_we     = wv && (w.rd != 3'd0);
        m_fromld = wld;
        if (wv) begin
            m_rd   = w.rd;
            m_data = w.data;
        end
    endtask

    task automatic set_idle();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = 3'd0;
        bus.alu_data  = 16'h0000;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = 3'd0;
        bus.mem_data  = 16'h0000;
        bus.ld_issue  = 1'b0;
        bus.ld_rd     = 3'd0;
        bus.rs1       = 3'd0;
        bus.rs2       = 3'd0;
    endtask

    task automatic cyc_pre();
        @(negedge clk);
        check_model();
    endtask

    task automatic cyc_post();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic cycle();
        cyc_pre();
        cyc_post();
    endtask

    task automatic check_vec(input vec_t v, input int idx);
        string s;
        s = $sformatf("vec%0d", idx);
        chk({s, "_rd_we"}, 16'(bus.rd_we), 16'(v.ewe));
        chk({s, "_rd"}, 16'(bus.rd), 16'(v.erd));
        chk({s, "_rd_data"}, bus.rd_data, v.edata);
        chk({s, "_mem_ready"}, 16'(bus.mem_ready), 16'(v.erdy));
        chk({s, "_rs1_busy"}, 16'(bus.rs1_busy), 16'(v.eb1 | (!FWD & v.em1)));
        chk({s, "_rs2_busy"}, 16'(bus.rs2_busy), 16'(v.eb2 | (!FWD & v.em2)));
        chk({s, "_fwd1_hit"}, 16'(bus.fwd1_hit), 16'(FWD & v.em1));
        chk({s, "_fwd2_hit"}, 16'(bus.fwd2_hit), 16'(FWD & v.em2));
    endtask

    initial begin
        logic [2:0] r;
        logic       acc;
        logic       issued;
        logic [2:0] issued_rd;

        checks = 0;
        errors = 0;
        cyc    = 0;
        m_we = 1'b0; m_rd = 3'd0; m_data = 16'h0000; m_fromld = 1'b0; m_busy = 8'h00;

        //          av   ard   ad        mv   mrd   md        li   lrd   rs1   rs2    we   rd    data      rdy  b1   m1   b2   m2
        vecs[0]  = '{1'b1,3'd3,16'h1234, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd3,3'd0,  1'b0,3'd0,16'h0000,1'b1,1'b0,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd5, 3'd3,3'd5,  1'b1,3'd3,16'h1234,1'b1,1'b0,1'b1,1'b0,1'b0};
        vecs[2]  = '{1'b0,3'd0,16'h0000, 1'b1,3'd5,16'hBEEF, 1'b0,3'd0, 3'd3,3'd5,  1'b0,3'd3,16'h1234,1'b1,1'b0,1'b0,1'b1,1'b0};
        vecs[3]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd0,3'd5,  1'b0,3'd3,16'h1234,1'b1,1'b0,1'b0,1'b1,1'b0};
        vecs[4]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd0,3'd5,  1'b1,3'd5,16'hBEEF,1'b1,1'b0,1'b0,1'b1,1'b1};
        vecs[5]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd1, 3'd1,3'd5,  1'b0,3'd5,16'hBEEF,1'b1,1'b0,1'b0,1'b0,1'b0};
        vecs[6]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd2, 3'd1,3'd2,  1'b0,3'd5,16'hBEEF,1'b1,1'b1,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd4, 3'd2,3'd4,  1'b0,3'd5,16'hBEEF,1'b1,1'b1,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b1,3'd6,16'h0006, 1'b1,3'd1,16'h1111, 1'b0,3'd0, 3'd4,3'd1,  1'b0,3'd5,16'hBEEF,1'b1,1'b1,1'b0,1'b1,1'b0};
        vecs[9]  = '{1'b1,3'd6,16'h0007, 1'b1,3'd2,16'h2222, 1'b0,3'd0, 3'd1,3'd2,  1'b1,3'd6,16'h0006,1'b1,1'b1,1'b0,1'b1,1'b0};
        vecs[10] = '{1'b1,3'd6,16'h0008, 1'b1,3'd4,16'h4444, 1'b0,3'd0, 3'd4,3'd6,  1'b1,3'd6,16'h0007,1'b0,1'b1,1'b0,1'b0,1'b1};
        vecs[11] = '{1'b1,3'd6,16'h0009, 1'b1,3'd4,16'h4444, 1'b0,3'd0, 3'd1,3'd4,  1'b1,3'd6,16'h0008,1'b0,1'b1,1'b0,1'b1,1'b0};
        vecs[12] = '{1'b0,3'd0,16'h0000, 1'b1,3'd4,16'h4444, 1'b0,3'd0, 3'd1,3'd2,  1'b1,3'd6,16'h0009,1'b0,1'b1,1'b0,1'b1,1'b0};
        vecs[13] = '{1'b0,3'd0,16'h0000, 1'b1,3'd4,16'h4444, 1'b0,3'd0, 3'd1,3'd2,  1'b1,3'd1,16'h1111,1'b1,1'b1,1'b1,1'b1,1'b0};
        vecs[14] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b1,3'd2, 3'd1,3'd2,  1'b1,3'd2,16'h2222,1'b1,1'b0,1'b0,1'b1,1'b1};
        vecs[15] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd4,3'd2,  1'b1,3'd4,16'h4444,1'b1,1'b1,1'b1,1'b1,1'b0};
        vecs[16] = '{1'b0,3'd0,16'h0000, 1'b1,3'd2,16'h2BAD, 1'b0,3'd0, 3'd4,3'd2,  1'b0,3'd4,16'h4444,1'b1,1'b0,1'b0,1'b1,1'b0};
        vecs[17] = '{1'b1,3'd0,16'hAAAA, 1'b1,3'd0,16'h0F0F, 1'b0,3'd0, 3'd0,3'd2,  1'b0,3'd4,16'h4444,1'b1,1'b0,1'b0,1'b1,1'b0};
        vecs[18] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd0,3'd2,  1'b0,3'd0,16'hAAAA,1'b0,1'b0,1'b0,1'b1,1'b0};
        vecs[19] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd0,3'd2,  1'b1,3'd2,16'h2BAD,1'b1,1'b0,1'b0,1'b1,1'b1};
        vecs[20] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd0,3'd2,  1'b0,3'd0,16'h0F0F,1'b1,1'b0,1'b0,1'b0,1'b0};
        vecs[21] = '{1'b0,3'd0,16'h0000, 1'b0,3'd0,16'h0000, 1'b0,3'd0, 3'd0,3'd2,  1'b0,3'd0,16'h0F0F,1'b1,1'b0,1'b0,1'b0,1'b0};

        // Reset held with an ALU write pending: nothing may reach the port.
        set_idle();
        rst_n         = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 3'd3;
        bus.alu_data  = 16'h5555;
        @(posedge clk);
        model_step();
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc_pre();
            chk("rst_rd_we", 16'(bus.rd_we), 16'h0000);
            cyc_post();
        end

        // First cycle after release.
        rst_n         = 1'b1;
        set_idle();
        bus.rs1       = 3'd3;
        bus.rs2       = 3'd5;
        cyc_pre();
        chk("rel_mem_ready", 16'(bus.mem_ready), 16'h0001);
        chk("rel_rs1_busy", 16'(bus.rs1_busy), 16'h0000);
        chk("rel_rs2_busy", 16'(bus.rs2_busy), 16'h0000);
        chk("rel_fwd1_hit", 16'(bus.fwd1_hit), 16'h0000);
        chk("rel_fwd2_hit", 16'(bus.fwd2_hit), 16'h0000);
        cyc_post();

        // Directed vector table.
        for (int i = 0; i < 22; i++) begin
            bus.alu_valid = vecs[i].av;
            bus.alu_rd    = vecs[i].ard;
            bus.alu_data  = vecs[i].ad;
            bus.mem_valid = vecs[i].mv;
            bus.mem_rd    = vecs[i].mrd;
            bus.mem_data  = vecs[i].md;
            bus.ld_issue  = vecs[i].li;
            bus.ld_rd     = vecs[i].lrd;
            bus.rs1       = vecs[i].r1;
            bus.rs2       = vecs[i].r2;
            cyc_pre();
            check_vec(vecs[i], i);
            cyc_post();
        end

        // Randomized traffic obeying the decode/execute protocol.
        iss_q.delete();
        for (int n = 0; n < 400; n++) begin
            set_idle();
            if ($urandom_range(0, 1) == 1) begin
                r = 3'($urandom_range(0, 7));
                if (m_busy[r]) r = 3'd0;
                bus.alu_valid = 1'b1;
                bus.alu_rd    = r;
                bus.alu_data  = 16'($urandom);
            end
            if (iss_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                bus.mem_valid = 1'b1;
                bus.mem_rd    = iss_q[0];
                bus.mem_data  = 16'($urandom);
            end
            issued    = 1'b0;
            issued_rd = 3'd0;
            if ($urandom_range(0, 3) == 0) begin
                r = 3'($urandom_range(0, 7));
                if (r == 3'd0 || !m_busy[r]) begin
                    bus.ld_issue = 1'b1;
                    bus.ld_rd    = r;
                    issued       = 1'b1;
                    issued_rd    = r;
                end
            end
            bus.rs1 = 3'($urandom_range(0, 7));
            bus.rs2 = 3'($urandom_range(0, 7));
            acc = bus.mem_valid && (m_q.size() < 2);
            cycle();
            if (acc) void'(iss_q.pop_front());
            if (issued) iss_q.push_back(issued_rd);
        end

        // Clean restart, then reset in the middle of buffered traffic.
        set_idle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        iss_q.delete();

        set_idle();
        bus.ld_issue = 1'b1; bus.ld_rd = 3'd3;
        cycle();
        set_idle();
        bus.ld_issue = 1'b1; bus.ld_rd = 3'd5;
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 16'h0101;
        cycle();
        set_idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 16'h0102;
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd3; bus.mem_data = 16'h3333;
        cycle();
        set_idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 16'h0103;
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd5; bus.mem_data = 16'h5555;
        cycle();
        set_idle();
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 16'h0104;
        bus.rs1 = 3'd3; bus.rs2 = 3'd5;
        rst_n = 1'b0;
        cyc_pre();
        chk("full_mem_ready", 16'(bus.mem_ready), 16'h0000);
        chk("full_rs1_busy", 16'(bus.rs1_busy), 16'h0001);
        cyc_post();
        rst_n = 1'b1;
        set_idle();
        bus.rs1 = 3'd3; bus.rs2 = 3'd5;
        cyc_pre();
        chk("midrst_mem_ready", 16'(bus.mem_ready), 16'h0001);
        chk("midrst_rd_we", 16'(bus.rd_we), 16'h0000);
        chk("midrst_rs1_busy", 16'(bus.rs1_busy), 16'h0000);
        chk("midrst_rs2_busy", 16'(bus.rs2_busy), 16'h0000);
        cyc_post();
        cyc_pre();
        chk("midrst_drained_we", 16'(bus.rd_we), 16'h0000);
        cyc_post();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
